// File: rtl/exmem_skid_reg_if.sv
// EX/MEM stage handshake bundle. It carries the upstream valid/ready plus the
// execute-stage payload, and the downstream valid/ready plus the head payload.
//   slave  : the skid register's view (consumes in_*, produces out_* and in_ready)
//   master : the surrounding pipeline's view (the opposite directions)
// Parameters: DATA_W (ALU result / store width), DEST_W (destination index width).
interface exmem_skid_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 4
);
    // upstream side
    logic              in_valid;
    logic              in_ready;
    logic              WB_en_in;
    logic              MEM_R_EN_in;
    logic              MEM_W_EN_in;
    logic [DATA_W-1:0] ALU_result_in;
    logic [DATA_W-1:0] ST_val_in;
    logic [DEST_W-1:0] Dest_in;
    // downstream side
    logic              out_valid;
    logic              out_ready;
    logic              WB_en;
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic [DATA_W-1:0] ALU_result;
    logic [DATA_W-1:0] ST_val;
    logic [DEST_W-1:0] Dest;

    modport slave (
        input  in_valid, WB_en_in, MEM_R_EN_in, MEM_W_EN_in,
        input  ALU_result_in, ST_val_in, Dest_in,
        output in_ready,
        output out_valid, WB_en, MEM_R_EN, MEM_W_EN, ALU_result, ST_val, Dest,
        input  out_ready
    );

    modport master (
        output in_valid, WB_en_in, MEM_R_EN_in, MEM_W_EN_in,
        output ALU_result_in, ST_val_in, Dest_in,
        input  in_ready,
        input  out_valid, WB_en, MEM_R_EN, MEM_W_EN, ALU_result, ST_val, Dest,
        output out_ready
    );
endinterface

// File: rtl/exmem_skid_reg.sv
// EX/MEM pipeline register implemented as a valid/ready skid buffer
// (2 entries, or 1 entry when DEPTH_TWO=0) with synchronous flush and a
// legacy global freeze.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : kills all held entries and the current input at the edge
//   freeze      : global stall, blocks both accept and pop
//   bus (slave) : upstream in_* / in_ready, downstream out_* / out_ready
//   stall_cnt   : (only with EXMEM_STALL_CNT_EN) saturating count of cycles
//                 with a valid head that was not consumed
// Optional feature macro: EXMEM_STALL_CNT_EN.
module exmem_skid_reg #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEST_W    = 4,
    parameter int unsigned DEPTH_TWO = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 freeze,
    exmem_skid_reg_if.slave      bus
`ifdef EXMEM_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);
    localparam bit TWO_EN = (DEPTH_TWO != 0);

    typedef struct packed {
        logic              wb;
        logic              mr;
        logic              mw;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] st;
        logic [DEST_W-1:0] dest;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_ent_c;
    logic   out_valid_c;
    logic   in_fire_c;
    logic   out_fire_c;

    assign in_ent_c = {bus.WB_en_in, bus.MEM_R_EN_in, bus.MEM_W_EN_in,
                       bus.ALU_result_in, bus.ST_val_in, bus.Dest_in};

    // Single-entry mode may accept while full only if the head pops in the same cycle.
    assign bus.in_ready = ~freeze & ~flush &
                          (TWO_EN ? (state_q != TWO)
                                  : ((state_q == EMPTY) | bus.out_ready));

    assign out_valid_c = (state_q != EMPTY);
    assign in_fire_c   = bus.in_valid & bus.in_ready;
    assign out_fire_c  = out_valid_c & bus.out_ready & ~freeze;

    // Head payload; control bits are gated so a bubble never writes.
    assign bus.out_valid  = out_valid_c;
    assign bus.WB_en      = head_q.wb & out_valid_c;
    assign bus.MEM_R_EN   = head_q.mr & out_valid_c;
    assign bus.MEM_W_EN   = head_q.mw & out_valid_c;
    assign bus.ALU_result = head_q.alu;
    assign bus.ST_val     = head_q.st;
    assign bus.Dest       = head_q.dest;

    // State and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state: flush beats freeze; data registers may keep stale values on flush.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (!freeze) begin
            case (state_q)
                EMPTY: begin
                    if (in_fire_c) begin
                        head_d  = in_ent_c;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire_c && out_fire_c) begin
                        head_d = in_ent_c;
                    end else if (in_fire_c && TWO_EN) begin
                        skid_d  = in_ent_c;
                        state_d = TWO;
                    end else if (out_fire_c) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire_c) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts every cycle a valid head is not consumed, including freeze cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (out_valid_c && !out_fire_c && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exmem_skid_reg.sv
// Self-checking bench for exmem_skid_reg: directed table, multi-cycle corner
// sequences, and randomized traffic against a queue-based reference model.
// Two DUTs share stimulus: u_dut2 (DEPTH_TWO=1) and u_dut1 (DEPTH_TWO=0).
module tb_exmem_skid_reg;
    logic clk;
    logic rst;
    logic flush;
    logic freeze;
    int   n_total;
    int   n_pass;

    exmem_skid_reg_if #(.DATA_W(32), .DEST_W(4)) bus2 ();
    exmem_skid_reg_if #(.DATA_W(32), .DEST_W(4)) bus1 ();

`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] stall_cnt2;
    logic [15:0] stall_cnt1;
`endif

    exmem_skid_reg #(.DATA_W(32), .DEST_W(4), .DEPTH_TWO(1)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .bus(bus2)
`ifdef EXMEM_STALL_CNT_EN
        , .stall_cnt(stall_cnt2)
`endif
    );

    exmem_skid_reg #(.DATA_W(32), .DEST_W(4), .DEPTH_TWO(0)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .bus(bus1)
`ifdef EXMEM_STALL_CNT_EN
        , .stall_cnt(stall_cnt1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] st;
        logic [3:0]  dest;
    } ent_t;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        frz;
        logic        fl;
        logic [31:0] alu;
        logic        exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_alu;
    } vec_t;

    // reference model: index 0 = two-entry DUT, index 1 = single-entry DUT
    ent_t q0[$];
    ent_t q1[$];
    ent_t shown[2];
    ent_t cur;
    logic cur_iv;
    logic cur_ordy;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic frz,
                         input logic fl, input ent_t e);
        cur = e; cur_iv = iv; cur_ordy = ordy;
        freeze = frz;
        flush  = fl;
        bus2.in_valid = iv;  bus1.in_valid = iv;
        bus2.out_ready = ordy; bus1.out_ready = ordy;
        bus2.WB_en_in = e.wb;  bus1.WB_en_in = e.wb;
        bus2.MEM_R_EN_in = e.mr; bus1.MEM_R_EN_in = e.mr;
        bus2.MEM_W_EN_in = e.mw; bus1.MEM_W_EN_in = e.mw;
        bus2.ALU_result_in = e.alu; bus1.ALU_result_in = e.alu;
        bus2.ST_val_in = e.st; bus1.ST_val_in = e.st;
        bus2.Dest_in = e.dest; bus1.Dest_in = e.dest;
    endtask

    function automatic ent_t mk(input logic [31:0] alu);
        ent_t e;
        e.wb = 1'b1; e.mr = alu[0]; e.mw = 1'b1;
        e.alu = alu; e.st = ~alu; e.dest = alu[3:0];
        return e;
    endfunction

    function automatic logic model_rdy(input int k);
        if (freeze || flush) return 1'b0;
        if (k == 0) return (q0.size() < 2);
        return (q1.size() == 0) || cur_ordy;
    endfunction

    // Advance the model by one clock edge using the pre-edge inputs.
    task automatic model_step();
        logic r0, r1;
        r0 = model_rdy(0);
        r1 = model_rdy(1);
        if (flush) begin
            q0.delete(); q1.delete();
        end else if (!freeze) begin
            if (q0.size() > 0 && cur_ordy) void'(q0.pop_front());
            if (q1.size() > 0 && cur_ordy) void'(q1.pop_front());
            if (cur_iv && r0) q0.push_back(cur);
            if (cur_iv && r1) q1.push_back(cur);
        end
        if (q0.size() > 0) shown[0] = q0[0];
        if (q1.size() > 0) shown[1] = q1[0];
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        shown[0] = '0; shown[1] = '0;
    endtask

    function automatic logic [95:0] exp_post(input int k);
        ent_t e;
        logic ov;
        ov = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
        e  = (k == 0) ? ((q0.size() > 0) ? q0[0] : shown[0])
                      : ((q1.size() > 0) ? q1[0] : shown[1]);
        return 96'({ov, e.wb & ov, e.mr & ov, e.mw & ov, e.alu, e.st, e.dest});
    endfunction

    function automatic logic [95:0] act_post2();
        return 96'({bus2.out_valid, bus2.WB_en, bus2.MEM_R_EN, bus2.MEM_W_EN,
                    bus2.ALU_result, bus2.ST_val, bus2.Dest});
    endfunction

    function automatic logic [95:0] act_post1();
        return 96'({bus1.out_valid, bus1.WB_en, bus1.MEM_R_EN, bus1.MEM_W_EN,
                    bus1.ALU_result, bus1.ST_val, bus1.Dest});
    endfunction

    vec_t tbl[22];

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // stream, back-pressure, flush in TWO, freeze, flush+freeze
        tbl[0]  = '{1, 1, 0, 0, 32'h01, 1, 1, 32'h01};
        tbl[1]  = '{1, 1, 0, 0, 32'h02, 1, 1, 32'h02};
        tbl[2]  = '{1, 1, 0, 0, 32'h03, 1, 1, 32'h03};
        tbl[3]  = '{1, 1, 0, 0, 32'h04, 1, 1, 32'h04};
        tbl[4]  = '{0, 1, 0, 0, 32'h00, 1, 0, 32'h04};
        tbl[5]  = '{1, 0, 0, 0, 32'h10, 1, 1, 32'h10};
        tbl[6]  = '{1, 0, 0, 0, 32'h20, 1, 1, 32'h10};
        tbl[7]  = '{0, 0, 0, 0, 32'h00, 0, 1, 32'h10};
        tbl[8]  = '{0, 1, 0, 0, 32'h00, 0, 1, 32'h20};
        tbl[9]  = '{0, 1, 0, 0, 32'h00, 1, 0, 32'h20};
        tbl[10] = '{1, 0, 0, 0, 32'h11, 1, 1, 32'h11};
        tbl[11] = '{1, 0, 0, 0, 32'h12, 1, 1, 32'h11};
        tbl[12] = '{1, 0, 0, 1, 32'h30, 0, 0, 32'h11};
        tbl[13] = '{0, 1, 0, 0, 32'h00, 1, 0, 32'h11};
        tbl[14] = '{1, 0, 0, 0, 32'h40, 1, 1, 32'h40};
        tbl[15] = '{1, 1, 1, 0, 32'h41, 0, 1, 32'h40};
        tbl[16] = '{1, 1, 1, 0, 32'h42, 0, 1, 32'h40};
        tbl[17] = '{1, 1, 1, 0, 32'h43, 0, 1, 32'h40};
        tbl[18] = '{0, 1, 0, 0, 32'h00, 1, 0, 32'h40};
        tbl[19] = '{0, 1, 0, 0, 32'h00, 1, 0, 32'h40};
        tbl[20] = '{1, 0, 0, 0, 32'h50, 1, 1, 32'h50};
        tbl[21] = '{0, 0, 1, 1, 32'h00, 0, 0, 32'h50};

        // power-on reset state
        #12;
        chk("reset_out", act_post2(), 96'h0);
        chk("reset_in_ready", 96'(bus2.in_ready), 96'h1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].frz, tbl[i].fl, mk(tbl[i].alu));
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 96'(bus2.in_ready), 96'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out", i),
                96'({bus2.out_valid, bus2.MEM_W_EN, bus2.ALU_result}),
                96'({tbl[i].exp_ov, tbl[i].exp_ov, tbl[i].exp_alu}));
        end

`ifdef EXMEM_STALL_CNT_EN
        // stall counter: clear, hold a head for 5 cycles, then flush
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        @(posedge clk); #1;
        chk("stall_clear", 96'(stall_cnt2), 96'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h60));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_five", 96'(stall_cnt2), 96'h5);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        @(posedge clk); #1;
        chk("stall_flush", 96'(stall_cnt2), 96'h0);
`endif

        // asynchronous reset mid-cycle while holding two entries
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h71));
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h72));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("two_in_ready", 96'(bus2.in_ready), 96'h0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out", act_post2(), 96'h0);
        #1 rst = 1'b0;
        #1;
        chk("midrst_in_ready", 96'(bus2.in_ready), 96'h1);
        @(posedge clk); #1;
        chk("midrst_stays_empty", act_post2(), 96'h0);

        // randomized traffic against the queue model, both depths
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            ent_t e;
            @(negedge clk);
            e.wb = 1'($urandom); e.mr = 1'($urandom); e.mw = 1'($urandom);
            e.alu = $urandom; e.st = $urandom; e.dest = 4'($urandom);
            drive(($urandom_range(3) != 0), 1'($urandom),
                  ($urandom_range(7) == 0), ($urandom_range(15) == 0), e);
            #1;
            chk("rnd_in_ready2", 96'(bus2.in_ready), 96'(model_rdy(0)));
            chk("rnd_in_ready1", 96'(bus1.in_ready), 96'(model_rdy(1)));
            model_step();
            @(posedge clk); #1;
            chk("rnd_out2", act_post2(), exp_post(0));
            chk("rnd_out1", act_post1(), exp_post(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/exmem_skid_reg.md
Name: exmem_skid_reg

Overview:
Parametrised successor to the EX/MEM pipeline register. It carries execute-stage results (write-back/memory control, ALU result, store value, destination) to the memory stage. It replaces the single freeze-gated register with a 2-entry valid/ready skid buffer, plus synchronous flush and legacy freeze. The memory stage (cache/SRAM controller) can now back-pressure without a global freeze, and the control-hazard unit can kill in-flight instructions.

Parameters:
DATA_W, 32, width of ALU result and store value
DEST_W, 4, width of destination register index
DEPTH_TWO, 1, 1 = 2-entry skid (full throughput under back-pressure); 0 = single entry (in_ready only when empty or popping)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous kill of all held entries and of the current input
freeze  in  1  legacy global stall; blocks accept and pop
in_valid  in  1  upstream entry valid
in_ready  out  1  buffer can accept this cycle
WB_en_in  in  1  write-back enable
MEM_R_EN_in  in  1  memory read
MEM_W_EN_in  in  1  memory write
ALU_result_in  in  DATA_W  ALU result / address
ST_val_in  in  DATA_W  store data
Dest_in  in  DEST_W  destination register
out_valid  out  1  head entry valid
out_ready  in  1  memory stage consumes head
WB_en  out  1  head WB enable, gated by out_valid
MEM_R_EN  out  1  head read, gated by out_valid
MEM_W_EN  out  1  head write, gated by out_valid
ALU_result  out  DATA_W  head ALU result
ST_val  out  DATA_W  head store value
Dest  out  DEST_W  head destination

Behaviour:
- Reset (async, rst=1): state EMPTY, out_valid=0, all control outputs 0, ALU_result/ST_val/Dest = 0, skid entry cleared.
- State: EMPTY, ONE (head valid), TWO (head + skid valid; only when DEPTH_TWO=1).
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & ~freeze.
- in_ready = ~freeze & ~flush & (state!=TWO). If DEPTH_TWO=0: ~freeze & ~flush & (state==EMPTY | out_ready). freeze/flush enter combinationally; the rest comes from registered state.
- Latency 1 cycle: an entry accepted at edge N appears on the outputs after edge N.
- Transitions (no flush):
  - EMPTY + in_fire -> ONE (head <= input).
  - ONE + in_fire & out_fire -> ONE (head <= input).
  - ONE + in_fire only -> TWO (skid <= input).
  - ONE + out_fire only -> EMPTY.
  - TWO + out_fire -> ONE (head <= skid).
  - TWO never accepts.
- Order is strictly FIFO. The skid entry is never exposed on the outputs before the head pops.
- WB_en/MEM_R_EN/MEM_W_EN = stored bit & out_valid. A bubble never writes.
- ALU_result/ST_val/Dest hold their last value when invalid; do not zero them.
- flush=1 at an edge: state -> EMPTY, out_valid=0. A same-cycle input is dropped. A same-cycle pop is not counted as consumed (downstream must also honour flush). Data registers may keep stale values.
- freeze=1: state and all registers hold. Outputs are unchanged (out_valid stays as-is). No pop occurs even if out_ready=1.
- flush and freeze both high: flush wins.
- rst mid-operation: immediate clear; no partial entry survives.

Optional Feature:
Macro EXMEM_STALL_CNT_EN.
- Defined: adds output stall_cnt (16 bits), reset 0, cleared by flush. It increments each cycle out_valid & ~out_fire and saturates at 16'hFFFF.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
1. Reset with rst pulsed asynchronously mid-cycle while in TWO -> out_valid=0, WB_en=MEM_R_EN=MEM_W_EN=0, ALU_result=0, in_ready=1 immediately after reset release.
2. Streaming: in_valid=1 every cycle, out_ready=1, ALU_result_in=1,2,3,4 -> outputs 1,2,3,4 on consecutive cycles, each one cycle after accept; in_ready stays 1.
3. Back-pressure (DEPTH_TWO=1): push A=0x10, B=0x20 with out_ready=0 -> in_ready=0 after B; raise out_ready -> pops 0x10 then 0x20; no loss or duplication.
4. Flush in TWO with simultaneous in_valid (C=0x30) -> next cycle out_valid=0, MEM_W_EN=0; C never appears on the outputs.
5. freeze=1 for 3 cycles with head=0x40, out_ready=1 -> 0x40 is held, in_ready=0; after freeze drops, 0x40 pops exactly once.
6. With EXMEM_STALL_CNT_EN: hold a valid head with out_ready=0 for 5 cycles -> stall_cnt=5; then flush -> stall_cnt=0.
